phrase_sequencer: RTL and testbench

//  Song-position sequencer for the music path: steps through a writable phrase-id table.

---
 rtl/phrase_sequencer.sv | 125 ++++++++++++
 tb/tb_phrase_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/phrase_sequencer.sv
// Song-position sequencer: plays a runtime-loadable phrase-id table one entry per bar_tick.
// Define SEQ_LOOP_EN to honour loop_en_i (wrap to LOOP_START); otherwise every song ends in DONE.
module phrase_sequencer #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned ID_W       = 5,
  parameter int unsigned SONG_LEN   = 153,
  parameter int unsigned LOOP_START = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [ID_W-1:0]   wr_data_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              bar_tick_i,
  input  logic              loop_en_i,
  output logic [ADDR_W-1:0] pos_o,
  output logic [ID_W-1:0]   phrase_id_o,
  output logic              phrase_valid_o,
  output logic              phrase_start_o,
  output logic              song_done_o
);

  localparam int unsigned   DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_POS = ADDR_W'(SONG_LEN - 1);
  localparam logic [ADDR_W-1:0] LOOP_POS = ADDR_W'(LOOP_START);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pos_q, pos_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              valid_q, valid_d;
  logic              pstart_q, pstart_d;
  logic              done_q, done_d;
  logic [ID_W-1:0]   tbl_q [DEPTH];

  logic              loop_active_c;
  logic              load_c;
  logic [ADDR_W-1:0] load_addr_c;

`ifdef SEQ_LOOP_EN
  assign loop_active_c = loop_en_i;
`else
  logic loop_unused_c;
  assign loop_active_c = 1'b0;
  assign loop_unused_c = ^{loop_en_i, LOOP_POS};
`endif

  // Phrase table: plain register file, not reset; a same-cycle load reads the old entry.
  always_ff @(posedge clk) begin
    if (wr_en_i) tbl_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pos_q    <= '0;
      id_q     <= '0;
      valid_q  <= 1'b0;
      pstart_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      id_q     <= id_d;
      valid_q  <= valid_d;
      pstart_q <= pstart_d;
      done_q   <= done_d;
    end
  end

  // Event priority: stop > start > bar_tick (PLAY only).
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    id_d        = id_q;
    valid_d     = valid_q;
    pstart_d    = 1'b0;
    done_d      = 1'b0;
    load_c      = 1'b0;
    load_addr_c = pos_q;

    if (stop_i) begin
      state_d = S_IDLE;
      pos_d   = '0;
      id_d    = '0;
      valid_d = 1'b0;
    end else if (start_i) begin
      load_c      = 1'b1;
      load_addr_c = '0;
    end else if (state_q == S_PLAY && bar_tick_i) begin
      if (pos_q != LAST_POS) begin
        load_c      = 1'b1;
        load_addr_c = pos_q + ADDR_W'(1);
      end else if (loop_active_c) begin
        load_c      = 1'b1;
        load_addr_c = LOOP_POS;
      end else begin
        state_d = S_DONE;
        valid_d = 1'b0;
        done_d  = 1'b1;
      end
    end

    // Every load moves pos and phrase_id together and (re)enters PLAY.
    if (load_c) begin
      state_d  = S_PLAY;
      pos_d    = load_addr_c;
      id_d     = tbl_q[load_addr_c];
      valid_d  = 1'b1;
      pstart_d = 1'b1;
    end
  end

  assign pos_o          = pos_q;
  assign phrase_id_o    = id_q;
  assign phrase_valid_o = valid_q;
  assign phrase_start_o = pstart_q;
  assign song_done_o    = done_q;

endmodule

// File: tb/tb_phrase_sequencer.sv
// Self-checking bench for phrase_sequencer: vector table, corner sequences, random vs. model.
module tb_phrase_sequencer;

  localparam int unsigned ADDR_W     = 3;
  localparam int unsigned ID_W       = 5;
  localparam int unsigned SONG_LEN   = 4;
  localparam int unsigned LOOP_START = 1;
  localparam int unsigned DEPTH      = 2**ADDR_W;
`ifdef SEQ_LOOP_EN
  localparam bit LOOP_BUILD = 1'b1;
`else
  localparam bit LOOP_BUILD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ID_W-1:0]   wr_data;
  logic              start, stop, bar_tick, loop_en;
  logic [ADDR_W-1:0] pos;
  logic [ID_W-1:0]   phrase_id;
  logic              phrase_valid, phrase_start, song_done;

  int checks = 0;
  int errors = 0;

  phrase_sequencer #(
    .ADDR_W(ADDR_W), .ID_W(ID_W), .SONG_LEN(SONG_LEN), .LOOP_START(LOOP_START)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .start_i(start), .stop_i(stop), .bar_tick_i(bar_tick), .loop_en_i(loop_en),
    .pos_o(pos), .phrase_id_o(phrase_id), .phrase_valid_o(phrase_valid),
    .phrase_start_o(phrase_start), .song_done_o(song_done)
  );

  always #5 clk = ~clk;

  // Behavioural reference: song state as plain integers and an array for the table.
  int        m_mode;  // 0 idle, 1 playing, 2 finished
  int        m_pos, m_id;
  bit        m_v, m_ps, m_d;
  int        m_tbl [DEPTH];

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_id = 0; m_v = 0; m_ps = 0; m_d = 0;
  endtask

  task automatic model_edge();
    int old_tbl [DEPTH];
    old_tbl = m_tbl;
    m_ps = 0; m_d = 0;
    if (stop) begin
      m_mode = 0; m_pos = 0; m_id = 0; m_v = 0;
    end else if (start) begin
      m_mode = 1; m_pos = 0; m_id = old_tbl[0]; m_v = 1; m_ps = 1;
    end else if (m_mode == 1 && bar_tick) begin
      if (m_pos < int'(SONG_LEN) - 1) begin
        m_pos = m_pos + 1; m_id = old_tbl[m_pos]; m_ps = 1;
      end else if (LOOP_BUILD && loop_en) begin
        m_pos = int'(LOOP_START); m_id = old_tbl[m_pos]; m_ps = 1;
      end else begin
        m_mode = 2; m_v = 0; m_d = 1;
      end
    end
    if (wr_en) m_tbl[wr_addr] = int'(wr_data);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input int e_pos, input int e_id,
                         input bit e_v, input bit e_ps, input bit e_d);
    chk({tag, ".pos"},          32'(pos),          32'(e_pos));
    chk({tag, ".phrase_id"},    32'(phrase_id),    32'(e_id));
    chk({tag, ".phrase_valid"}, 32'(phrase_valid), 32'(e_v));
    chk({tag, ".phrase_start"}, 32'(phrase_start), 32'(e_ps));
    chk({tag, ".song_done"},    32'(song_done),    32'(e_d));
  endtask

  // Drive one cycle of inputs, clock it, update the model, sample 1 ns after the edge.
  task automatic step(input logic we, input int wa, input int wd,
                      input logic st, input logic sp, input logic bt, input logic le);
    wr_en = we; wr_addr = ADDR_W'(wa); wr_data = ID_W'(wd);
    start = st; stop = sp; bar_tick = bt; loop_en = le;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic we; int wa; int wd; logic st; logic sp; logic bt; logic le;
    int e_pos; int e_id; bit e_v; bit e_ps; bit e_d;
  } vec_t;

  vec_t vecs [22];

  initial begin
    //         we wa wd st sp bt le  pos id v ps d
    vecs[0]  = '{1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    vecs[1]  = '{1, 1, 2, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    vecs[2]  = '{1, 2, 3, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    vecs[3]  = '{1, 3, 4, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    vecs[4]  = '{0, 0, 0, 1, 0, 0, 0,  0, 1, 1, 1, 0};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 1, 0,  1, 2, 1, 1, 0};
    vecs[7]  = '{0, 0, 0, 0, 0, 1, 0,  2, 3, 1, 1, 0};
    vecs[8]  = '{0, 0, 0, 0, 0, 1, 0,  3, 4, 1, 1, 0};
    vecs[9]  = '{0, 0, 0, 0, 0, 1, 0,  3, 4, 0, 0, 1};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 0,  3, 4, 0, 0, 0};
    vecs[11] = '{0, 0, 0, 0, 0, 1, 0,  3, 4, 0, 0, 0};
    vecs[12] = '{0, 0, 0, 1, 0, 1, 0,  0, 1, 1, 1, 0};
    vecs[13] = '{0, 0, 0, 0, 0, 1, 0,  1, 2, 1, 1, 0};
    vecs[14] = '{0, 0, 0, 0, 0, 1, 0,  2, 3, 1, 1, 0};
    vecs[15] = '{0, 0, 0, 1, 0, 1, 0,  0, 1, 1, 1, 0};
    vecs[16] = '{0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0};
    vecs[17] = '{0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0};
    vecs[18] = '{1, 0, 9, 1, 0, 0, 0,  0, 1, 1, 1, 0};
    vecs[19] = '{0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0};
    vecs[20] = '{0, 0, 0, 1, 0, 0, 0,  0, 9, 1, 1, 0};
    vecs[21] = '{1, 0, 1, 0, 0, 0, 0,  0, 9, 1, 0, 0};

    for (int a = 0; a < int'(DEPTH); a++) m_tbl[a] = 0;
    rst = 1'b1;
    wr_en = 0; wr_addr = '0; wr_data = '0;
    start = 0; stop = 0; bar_tick = 0; loop_en = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Table fill, basic play to DONE, restart/stop priorities, write-vs-load ordering.
    for (int i = 0; i < 22; i++) begin
      step(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].st, vecs[i].sp, vecs[i].bt, vecs[i].le);
      chk_out($sformatf("vec%0d", i), vecs[i].e_pos, vecs[i].e_id,
              vecs[i].e_v, vecs[i].e_ps, vecs[i].e_d);
    end

    // End of song with loop_en=1: wraps to LOOP_START only in the looping build.
    step(0, 0, 0, 0, 0, 1, 1); chk_out("lp1", 1, 2, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1); chk_out("lp2", 2, 3, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1); chk_out("lp3", 3, 4, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    chk_out("lpwrap", LOOP_BUILD ? 1 : 3, LOOP_BUILD ? 2 : 4,
            LOOP_BUILD, LOOP_BUILD, !LOOP_BUILD);
    step(0, 0, 0, 0, 1, 0, 0); chk_out("lpstop", 0, 0, 0, 0, 0);

    // Writing the entry currently shown leaves phrase_id alone until it is reloaded.
    step(0, 0, 0, 1, 0, 0, 0); chk_out("wr_s", 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0); chk_out("wr_t1", 1, 2, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0); chk_out("wr_t2", 2, 3, 1, 1, 0);
    step(1, 2, 7, 0, 0, 0, 0); chk_out("wr_hold", 2, 3, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0); chk_out("wr_rs", 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0); chk_out("wr_r1", 1, 2, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0); chk_out("wr_new", 2, 7, 1, 1, 0);

    // bar_tick ignored in IDLE and in DONE.
    step(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0, 1, 0); chk_out("idle_tick", 0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 0);
    chk_out("to_done", 3, 4, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0, 1, 1'($urandom_range(1))); chk_out("done_tick", 3, 4, 0, 0, 0);
    end

    // Asynchronous reset in the middle of PLAY clears outputs without waiting for an edge.
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0); chk_out("pre_rst", 2, 7, 1, 1, 0);
    wr_en = 0; start = 0; stop = 0; bar_tick = 0;
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk_out("rst_async", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_out("rst_hold", 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 1, 0); chk_out("rst_idle", 0, 0, 0, 0, 0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(3) == 0), int'($urandom_range(DEPTH - 1)),
           int'($urandom_range(31)), 1'($urandom_range(9) == 0),
           1'($urandom_range(19) == 0), 1'($urandom_range(1)), 1'($urandom_range(1)));
      chk_out("rand", m_pos, m_id, m_v, m_ps, m_d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
